// File: rtl/lamp_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module   : lamp_ctrl_n
// Purpose  : N-way lamp controller. Any accepted change on any wall switch
//            toggles the lamp. Each raw switch level is synchronised and
//            debounced before use. An optional auto-off timer switches the
//            lamp off after a period of switch inactivity. A force-off input
//            overrides everything else.
// Ports    : clk         - system clock, rising edge
//            rst_n       - asynchronous active-low reset
//            sw          - raw switch levels (asynchronous to clk)
//            force_off   - synchronous force-off, highest priority
//            F           - registered lamp drive
//            sw_stable   - debounced switch levels
//            toggle_evt  - one-cycle pulse when F toggles due to switches
//            timeout_evt - one-cycle pulse when auto-off clears F
// Revision : 1.0 - initial release
// ============================================================================
module lamp_ctrl_n #(
   parameter int N_SW    = 3,
   parameter int DEB_CYC = 8,
   parameter int TIMEOUT = 1000,
   parameter int TIMER_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_SW-1:0] sw,
   input  logic            force_off,
   output logic            F,
   output logic [N_SW-1:0] sw_stable,
   output logic            toggle_evt,
   output logic            timeout_evt
);

   localparam logic [7:0]         C_DEB_LAST = 8'(DEB_CYC - 1);
   localparam logic [7:0]         C_DEB_ONE  = 8'd1;
   localparam bit                 C_TMO_EN   = (TIMEOUT != 0);
   // Guarded so a disabled timer does not produce a negative constant.
   localparam logic [TIMER_W-1:0] C_TMO_LAST = TIMER_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam logic [TIMER_W-1:0] C_TMR_ONE  = TIMER_W'(1);

   // Synchroniser, debounce and edge-detect state
   logic [N_SW-1:0]    sync1_q;
   logic [N_SW-1:0]    sync2_q;
   logic [N_SW-1:0]    stable_q;
   logic [N_SW-1:0]    stable_d;
   logic [N_SW-1:0]    stable_prev_q;
   logic [7:0]         cnt_q [N_SW];
   logic [7:0]         cnt_d [N_SW];

   // Lamp state
   logic               f_q;
   logic               f_d;
   logic [TIMER_W-1:0] timer_q;
   logic [TIMER_W-1:0] timer_d;
   logic               toggle_q;
   logic               toggle_d;
   logic               timeout_q;
   logic               timeout_d;

   logic [N_SW-1:0]    chg;
   logic               odd;

   // Per-bit debounce: a new synchronised level must persist for DEB_CYC
   // consecutive cycles before it replaces the stable level.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      for (int i = 0; i < N_SW; i++) begin
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == C_DEB_LAST) begin
            stable_d[i] = sync2_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + C_DEB_ONE;
         end
      end
   end

   // An odd number of simultaneous edges flips the parity of the switch
   // word, so the lamp toggles; an even number leaves parity unchanged.
   assign chg = stable_q ^ stable_prev_q;
   assign odd = ^chg;

   always_comb begin
      f_d       = f_q;
      timer_d   = timer_q;
      toggle_d  = 1'b0;
      timeout_d = 1'b0;
      if (force_off) begin
         f_d     = 1'b0;
         timer_d = '0;
      end else if (|chg) begin
         // Switch activity beats a coinciding timeout expiry.
         timer_d = '0;
         if (odd) begin
            f_d      = ~f_q;
            toggle_d = 1'b1;
         end
      end else if (C_TMO_EN && f_q && (timer_q == C_TMO_LAST)) begin
         f_d       = 1'b0;
         timer_d   = '0;
         timeout_d = 1'b1;
      end else if (f_q) begin
         timer_d = timer_q + C_TMR_ONE;
      end else begin
         timer_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         stable_q      <= '0;
         stable_prev_q <= '0;
         for (int i = 0; i < N_SW; i++) begin
            cnt_q[i] <= '0;
         end
         f_q           <= 1'b0;
         timer_q       <= '0;
         toggle_q      <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         sync1_q       <= sw;
         sync2_q       <= sync1_q;
         stable_q      <= stable_d;
         stable_prev_q <= stable_q;
         for (int i = 0; i < N_SW; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         f_q           <= f_d;
         timer_q       <= timer_d;
         toggle_q      <= toggle_d;
         timeout_q     <= timeout_d;
      end
   end

   assign F           = f_q;
   assign sw_stable   = stable_q;
   assign toggle_evt  = toggle_q;
   assign timeout_evt = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_lamp_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_lamp_ctrl_n
// Purpose  : Scoreboard bench for lamp_ctrl_n (N_SW=3, DEB_CYC=4, TIMEOUT=20).
//            Stimulus pushes each expected lamp event (kind, lamp value,
//            cycle) into a queue; a monitor pops and compares every pulse
//            on toggle_evt / timeout_evt, and flags missed events.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lamp_ctrl_n;

   logic       clk;
   logic       rst_n;
   logic [2:0] sw;
   logic       force_off;
   logic       F;
   logic [2:0] sw_stable;
   logic       toggle_evt;
   logic       timeout_evt;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      bit is_to;
      bit f;
      int at;
   } evt_t;

   evt_t q[$];

   lamp_ctrl_n #(
      .N_SW    (3),
      .DEB_CYC (4),
      .TIMEOUT (20),
      .TIMER_W (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sw          (sw),
      .force_off   (force_off),
      .F           (F),
      .sw_stable   (sw_stable),
      .toggle_evt  (toggle_evt),
      .timeout_evt (timeout_evt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input bit is_to, input bit f, input int at);
      evt_t e;
      e.is_to = is_to;
      e.f     = f;
      e.at    = at;
      q.push_back(e);
   endtask

   // Monitor: every output pulse must match the head of the queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (toggle_evt && timeout_evt) begin
            checks++;
            errors++;
            $display("FAIL both_evt: toggle_evt and timeout_evt high together at cycle %0d", cyc);
         end else if (toggle_evt || timeout_evt) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_evt: timeout=%0d F=%0d at cycle %0d, none expected",
                        timeout_evt, F, cyc);
            end else begin
               evt_t e;
               e = q.pop_front();
               if (e.is_to != timeout_evt || e.f != F || e.at != cyc) begin
                  errors++;
                  $display("FAIL evt: got timeout=%0d F=%0d cycle=%0d expected timeout=%0d F=%0d cycle=%0d",
                           timeout_evt, F, cyc, e.is_to, e.f, e.at);
               end
            end
         end else if (q.size() > 0 && q[0].at < cyc) begin
            evt_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_evt: got no pulse expected timeout=%0d F=%0d at cycle %0d",
                     e.is_to, e.f, e.at);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000 ns");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0] walk [7];
      bit         walk_f [7];
      int         d;

      walk   = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
      walk_f = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

      rst_n     = 1'b0;
      sw        = 3'b000;
      force_off = 1'b0;
      repeat (3) step();
      chk("reset_F", int'(F), 0);
      chk("reset_stable", int'(sw_stable), 0);
      chk("reset_toggle", int'(toggle_evt), 0);
      chk("reset_timeout", int'(timeout_evt), 0);
      rst_n = 1'b1;
      repeat (3) step();

      // Gray-code walk, each step held under the timeout so F tracks parity.
      d = 0;
      for (int i = 0; i < 7; i++) begin
         d  = cyc;
         sw = walk[i];
         push(1'b0, walk_f[i], d + 7);
         repeat (12) step();
         chk("walk_stable", int'(sw_stable), int'(walk[i]));
         chk("walk_F", int'(F), int'(walk_f[i]));
      end
      // Last step left F=1: auto-off 20 cycles after the toggle.
      push(1'b1, 1'b0, d + 27);
      repeat (25) step();
      chk("auto_off_F", int'(F), 0);

      // 3-cycle glitch rejected.
      sw = 3'b101;
      repeat (3) step();
      sw = 3'b100;
      repeat (15) step();
      chk("glitch_stable", int'(sw_stable), 3'b100);
      chk("glitch_F", int'(F), 0);

      // 4-cycle pulse accepted on both edges.
      d  = cyc;
      sw = 3'b101;
      push(1'b0, 1'b1, d + 7);
      repeat (4) step();
      sw = 3'b100;
      push(1'b0, 1'b0, d + 11);
      repeat (15) step();
      chk("pulse4_stable", int'(sw_stable), 3'b100);
      chk("pulse4_F", int'(F), 0);

      // Two simultaneous edges: stable word changes in one cycle, no toggle.
      d  = cyc;
      sw = 3'b111;
      repeat (5) step();
      chk("simul_stable_before", int'(sw_stable), 3'b100);
      step();
      chk("simul_stable_after", int'(sw_stable), 3'b111);
      repeat (6) step();
      chk("simul_F", int'(F), 0);

      // Single edge toggles on; edge 15 cycles later toggles off before timeout.
      d  = cyc;
      sw = 3'b011;
      push(1'b0, 1'b1, d + 7);
      repeat (15) step();
      sw = 3'b001;
      push(1'b0, 1'b0, d + 22);
      repeat (30) step();
      chk("restart_F", int'(F), 0);
      chk("restart_stable", int'(sw_stable), 3'b001);

      // Full auto-off.
      d  = cyc;
      sw = 3'b000;
      push(1'b0, 1'b1, d + 7);
      push(1'b1, 1'b0, d + 27);
      repeat (35) step();
      chk("timeout_F", int'(F), 0);

      // Switch edge lands exactly on timeout expiry: toggle wins.
      d  = cyc;
      sw = 3'b001;
      push(1'b0, 1'b1, d + 7);
      repeat (20) step();
      sw = 3'b000;
      push(1'b0, 1'b0, d + 27);
      repeat (30) step();
      chk("coincide_F", int'(F), 0);

      // force_off in the same cycle a switch edge is applied.
      d  = cyc;
      sw = 3'b001;
      push(1'b0, 1'b1, d + 7);
      repeat (10) step();
      sw = 3'b011;
      repeat (6) step();
      force_off = 1'b1;
      step();
      force_off = 1'b0;
      chk("force_F", int'(F), 0);
      chk("force_toggle", int'(toggle_evt), 0);
      repeat (10) step();
      chk("force_F_later", int'(F), 0);
      chk("force_stable", int'(sw_stable), 3'b011);

      // Reset mid-debounce (counters at 2) with 101 driven.
      sw = 3'b101;
      repeat (4) step();
      rst_n = 1'b0;
      #1;
      chk("midrst_F", int'(F), 0);
      chk("midrst_stable", int'(sw_stable), 0);
      chk("midrst_toggle", int'(toggle_evt), 0);
      repeat (3) step();
      rst_n = 1'b1;
      repeat (5) step();
      chk("rerel_stable_before", int'(sw_stable), 0);
      step();
      chk("rerel_stable_after", int'(sw_stable), 3'b101);
      repeat (4) step();
      chk("rerel_F", int'(F), 0);

      repeat (5) step();
      chk("queue_empty", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
